ps2_key_event_rx: RTL and testbench

//  Parametrised PS/2 keyboard front end for the piano top level. Receives raw
//  PS2_CLK/PS2_DAT, validates each 11-bit frame and decodes the E0/F0/E1

---
 rtl/ps2_key_event_rx.sv | 208 ++++++++++++++++++++
 tb/tb_ps2_key_event_rx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_rx.sv
// rtl/ps2_key_event_rx.sv - PS/2 keyboard receiver: frame check, E0/F0/E1 decode, event FIFO
module ps2_key_event_rx #(
    parameter int FIFO_DEPTH  = 8,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic                            CLOCK_50,
    input  logic                            reset,
    input  logic                            PS2_CLK,
    input  logic                            PS2_DAT,
    output logic                            ev_valid,
    input  logic                            ev_ready,
    output logic [7:0]                      ev_code,
    output logic                            ev_ext,
    output logic                            ev_break,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow,
    output logic                            err_pulse,
    output logic [7:0]                      err_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] FLT_LAST   = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYC - 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_CHECK} state_t;

    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic          r_clk_filt;
    logic [FW-1:0] r_filt_cnt;
    logic          w_fall;

    state_t        r_state, w_state_next;
    logic [3:0]    r_bit_cnt;
    logic [9:0]    r_shift;
    logic [TW-1:0] r_idle_cnt;
    logic          w_frame_ok, w_frame_err, w_timeout;

    logic          r_ext, r_brk;
    logic [2:0]    r_skip;
    logic [7:0]    w_byte;
    logic          w_push;
    logic [9:0]    w_push_data;

    logic [9:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_overflow, r_err_pulse;
    logic [7:0]    r_err_count;
    logic          w_full, w_pop, w_wr_en;
    logic [9:0]    w_head;

    // Synchronisers idle high so reset never looks like a falling edge.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= PS2_CLK;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= PS2_DAT;
            r_dat_s2 <= r_dat_s1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_clk_filt <= 1'b1;
            r_filt_cnt <= '0;
        end else if (r_clk_s2 == r_clk_filt) begin
            r_filt_cnt <= '0;
        end else if (r_filt_cnt == FLT_LAST) begin
            r_clk_filt <= r_clk_s2;
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
        end
    end

    assign w_fall = r_clk_filt & ~r_clk_s2 & (r_filt_cnt == FLT_LAST);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_frame_ok   = 1'b0;
        w_frame_err  = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fall && !r_dat_s2) w_state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (w_fall) begin
                    if (r_bit_cnt == 4'd9) w_state_next = ST_CHECK;
                end else if (r_idle_cnt == TO_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_CHECK: begin
                w_state_next = ST_IDLE;
                // shift = {stop, parity, data}; odd parity over data+parity
                if ((^r_shift[8:0]) && r_shift[9]) w_frame_ok  = 1'b1;
                else                               w_frame_err = 1'b1;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_idle_cnt <= '0;
        end else if (r_state == ST_SHIFT) begin
            if (w_fall) begin
                r_shift    <= {r_dat_s2, r_shift[9:1]};
                r_bit_cnt  <= r_bit_cnt + 1'b1;
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
        end else begin
            r_bit_cnt  <= '0;
            r_idle_cnt <= '0;
        end
    end

    assign w_byte      = r_shift[7:0];
    assign w_push_data = {r_ext, r_brk, w_byte};
    assign w_push      = w_frame_ok && (r_skip == 3'd0) &&
                         (w_byte != 8'hE0) && (w_byte != 8'hF0) && (w_byte != 8'hE1);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_ext  <= 1'b0;
            r_brk  <= 1'b0;
            r_skip <= '0;
        end else if (w_frame_err || w_timeout) begin
            r_ext  <= 1'b0;
            r_brk  <= 1'b0;
            r_skip <= '0;
        end else if (w_frame_ok) begin
            if (r_skip != 3'd0)      r_skip <= r_skip - 1'b1;
            else if (w_byte == 8'hE0) r_ext  <= 1'b1;
            else if (w_byte == 8'hF0) r_brk  <= 1'b1;
            else if (w_byte == 8'hE1) r_skip <= 3'd7;
            else begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end
        end
    end

    assign w_full  = (r_level == LEVEL_FULL);
    assign w_pop   = ev_valid & ev_ready;
    assign w_wr_en = w_push & (~w_full | w_pop);
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge CLOCK_50) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= w_push_data;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr_en && !w_pop)      r_level <= r_level + 1'b1;
            else if (!w_wr_en && w_pop) r_level <= r_level - 1'b1;
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_err_pulse <= w_frame_err | w_timeout;
            if ((w_frame_err || w_timeout) && r_err_count != 8'hFF)
                r_err_count <= r_err_count + 1'b1;
        end
    end

    // Head fields are masked so stale RAM never shows on an empty FIFO.
    assign ev_valid   = (r_level != '0);
    assign ev_code    = ev_valid ? w_head[7:0] : 8'h00;
    assign ev_break   = ev_valid & w_head[8];
    assign ev_ext     = ev_valid & w_head[9];
    assign fifo_level = r_level;
    assign overflow   = r_overflow;
    assign err_pulse  = r_err_pulse;
    assign err_count  = r_err_count;
endmodule

// File: tb/tb_ps2_key_event_rx.sv
// tb/tb_ps2_key_event_rx.sv - directed table-driven bench for ps2_key_event_rx
module tb_ps2_key_event_rx;
    localparam int FIFO_DEPTH  = 8;
    localparam int FILTER_LEN  = 4;
    localparam int TIMEOUT_CYC = 5000;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       PS2_CLK  = 1'b1;
    logic       PS2_DAT  = 1'b1;
    logic       ev_ready = 1'b1;
    logic       ev_valid, ev_ext, ev_break, overflow, err_pulse;
    logic [7:0] ev_code, err_count;
    logic [3:0] fifo_level;

    ps2_key_event_rx #(.FIFO_DEPTH(FIFO_DEPTH), .FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext),
        .ev_break(ev_break), .fifo_level(fifo_level), .overflow(overflow),
        .err_pulse(err_pulse), .err_count(err_count)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int              n;
        logic [9:0][7:0] b;
        logic [9:0]      bad;
        int              nev;
        logic [7:0]      code;
        logic            ext;
        logic            brk;
        int              nerr;
    } vec_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         last_fall_cyc = 0;
    int         first_valid_cyc = -1;
    int         valid_cycles = 0;
    int         err_pulses = 0;
    int         exp_err_total = 0;
    logic [9:0] ev_q [$];
    vec_t       vecs [10];

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    always @(negedge CLOCK_50) begin
        if (ev_valid) begin
            valid_cycles = valid_cycles + 1;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (ev_valid && ev_ready) ev_q.push_back({ev_ext, ev_break, ev_code});
        if (err_pulse) err_pulses = err_pulses + 1;
    end

    function automatic vec_t mk(int n, logic [79:0] bytes_flat, logic [9:0] bad, int nev,
                                logic [7:0] code, logic ext, logic brk, int nerr);
        vec_t v;
        v.n = n; v.b = bytes_flat; v.bad = bad; v.nev = nev;
        v.code = code; v.ext = ext; v.brk = brk; v.nerr = nerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic clear_mon();
        ev_q.delete();
        valid_cycles    = 0;
        first_valid_cyc = -1;
        err_pulses      = 0;
    endtask

    task automatic send_raw(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            PS2_DAT = bits[i];
            wait_cyc(10);
            PS2_CLK = 1'b0;
            last_fall_cyc = cyc;
            wait_cyc(20);
            PS2_CLK = 1'b1;
            wait_cyc(10);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad);
        send_raw({1'b1, (~^b) ^ bad, b, 1'b0}, 11);
        wait_cyc(20);
    endtask

    task automatic chk_event(input string name, input logic [7:0] code, input logic ext, input logic brk);
        logic [9:0] e;
        e = (ev_q.size() > 0) ? ev_q.pop_front() : 10'h3FF;
        chk({name, "_event"}, {22'd0, e}, {22'd0, ext, brk, code});
    endtask

    initial begin
        vecs[0] = mk(1, 80'h1C,                   10'b0,   1, 8'h1C, 1'b0, 1'b0, 0);
        vecs[1] = mk(2, 80'h1C_F0,                10'b0,   1, 8'h1C, 1'b0, 1'b1, 0);
        vecs[2] = mk(3, 80'h75_F0_E0,             10'b0,   1, 8'h75, 1'b1, 1'b1, 0);
        vecs[3] = mk(2, 80'h74_E0,                10'b0,   1, 8'h74, 1'b1, 1'b0, 0);
        vecs[4] = mk(1, 80'h1C,                   10'b1,   0, 8'h00, 1'b0, 1'b0, 1);
        vecs[5] = mk(1, 80'h1C,                   10'b0,   1, 8'h1C, 1'b0, 1'b0, 0);
        vecs[6] = mk(9, 80'h2B_77_F0_14_F0_E1_77_14_E1, 10'b0, 1, 8'h2B, 1'b0, 1'b0, 0);
        vecs[7] = mk(3, 80'h1C_1C_E0,             10'b010, 1, 8'h1C, 1'b0, 1'b0, 1);
        vecs[8] = mk(3, 80'h33_14_E1,             10'b010, 1, 8'h33, 1'b0, 1'b0, 1);
        vecs[9] = mk(3, 80'h29_F0_F0,             10'b0,   1, 8'h29, 1'b0, 1'b1, 0);

        wait_cyc(3);
        chk("rst_valid", {31'd0, ev_valid}, 32'd0);
        chk("rst_outs", {17'd0, ev_code, ev_ext, ev_break, overflow, err_pulse, fifo_level},
            32'd0);
        chk("rst_errcnt", {24'd0, err_count}, 32'd0);
        reset = 1'b0;
        wait_cyc(10);

        for (int i = 0; i < 10; i++) begin
            clear_mon();
            for (int k = 0; k < vecs[i].n; k++) send_byte(vecs[i].b[k], vecs[i].bad[k]);
            wait_cyc(20);
            exp_err_total = exp_err_total + vecs[i].nerr;
            chk($sformatf("v%0d_nev", i), ev_q.size(), vecs[i].nev);
            chk($sformatf("v%0d_validcyc", i), valid_cycles, vecs[i].nev);
            chk($sformatf("v%0d_errpulse", i), err_pulses, vecs[i].nerr);
            chk($sformatf("v%0d_errcnt", i), {24'd0, err_count}, exp_err_total);
            if (vecs[i].nev == 1) begin
                chk($sformatf("v%0d_latency_ok", i),
                    ((first_valid_cyc - last_fall_cyc) > 0 &&
                     (first_valid_cyc - last_fall_cyc) <= FILTER_LEN + 5) ? 32'd1 : 32'd0, 32'd1);
                chk_event($sformatf("v%0d", i), vecs[i].code, vecs[i].ext, vecs[i].brk);
            end
        end

        // Overflow: nine codes into an 8-deep FIFO with the consumer stalled.
        clear_mon();
        ev_ready = 1'b0;
        for (int k = 0; k < FIFO_DEPTH + 1; k++) send_byte(8'h10 + 8'(k), 1'b0);
        chk("ovf_level", {28'd0, fifo_level}, FIFO_DEPTH);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        ev_ready = 1'b1;
        wait_cyc(20);
        chk("ovf_drain_n", ev_q.size(), FIFO_DEPTH);
        for (int k = 0; k < FIFO_DEPTH; k++)
            chk_event($sformatf("ovf_drain%0d", k), 8'h10 + 8'(k), 1'b0, 1'b0);
        chk("ovf_empty_valid", {31'd0, ev_valid}, 32'd0);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Timeout: five edges then a silent clock line.
        clear_mon();
        send_raw(11'b000_0010_1010, 5);
        wait_cyc(6000);
        exp_err_total = exp_err_total + 1;
        chk("to_errpulse", err_pulses, 32'd1);
        chk("to_errcnt", {24'd0, err_count}, exp_err_total);
        chk("to_noevent", ev_q.size(), 32'd0);
        clear_mon();
        send_byte(8'h15, 1'b0);
        wait_cyc(20);
        chk("to_next_n", ev_q.size(), 32'd1);
        chk_event("to_next", 8'h15, 1'b0, 1'b0);

        // Reset mid-frame with events queued and an E0 prefix pending.
        clear_mon();
        ev_ready = 1'b0;
        send_byte(8'h21, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h23, 1'b0);
        chk("rstm_level3", {28'd0, fifo_level}, 32'd3);
        send_byte(8'hE0, 1'b0);
        send_raw({1'b1, 1'b0, 8'h1C, 1'b0}, 6);
        reset = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(5);
        exp_err_total = 0;
        chk("rstm_level", {28'd0, fifo_level}, 32'd0);
        chk("rstm_ovf", {31'd0, overflow}, 32'd0);
        chk("rstm_valid", {31'd0, ev_valid}, 32'd0);
        chk("rstm_errcnt", {24'd0, err_count}, 32'd0);
        ev_ready = 1'b1;
        clear_mon();
        send_byte(8'h1C, 1'b0);
        wait_cyc(20);
        chk("rstm_next_n", ev_q.size(), 32'd1);
        chk_event("rstm_next", 8'h1C, 1'b0, 1'b0);
        chk("rstm_next_err", err_pulses, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
